// File: rtl/sprite_reader.sv
// Sprite read pipeline: maps screen coordinates to sprite RAM addresses and
// returns a keyed sprite pixel three clocks after the coordinate is presented.
module sprite_reader #(
    parameter int unsigned           DATA_WIDTH    = 12,
    parameter int unsigned           ADDR_WIDTH    = 15,
    parameter int unsigned           SPRITE_W_LOG2 = 7,
    parameter int unsigned           SPRITE_H      = 128,
    parameter int unsigned           SCALE_LOG2    = 0,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT   = 12'hFFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic [9:0]            origin_x,
    input  logic [9:0]            origin_y,
    input  logic [9:0]            pixel_column,
    input  logic [9:0]            pixel_row,
    input  logic                  video_on,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_valid
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned DIFF_W  = COORD_W + 1;
    localparam int unsigned BOX_W   = (32'd1 << SPRITE_W_LOG2) << SCALE_LOG2;
    localparam int unsigned BOX_H   = SPRITE_H << SCALE_LOG2;

    logic [COORD_W-1:0]    ox_q, oy_q;
    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
    logic                  hit1_q, hit1_d;
    logic                  hit2_q;
    logic [DATA_WIDTH-1:0] pixel_out_q, pixel_out_d;
    logic                  pixel_valid_q, pixel_valid_d;

    logic [DIFF_W-1:0]     dx, dy;
    logic                  in_box;

    // Shadow origin: only reloaded during vertical blanking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ox_q <= '0;
            oy_q <= '0;
        end else if (frame_start) begin
            ox_q <= origin_x;
            oy_q <= origin_y;
        end
    end

    // Stage 0: 11-bit differences; the top bit is the borrow (left of / above sprite)
    always_comb begin
        dx          = {1'b0, pixel_column} - {1'b0, ox_q};
        dy          = {1'b0, pixel_row}    - {1'b0, oy_q};
        in_box      = !dx[DIFF_W-1] && !dy[DIFF_W-1]
                      && (32'(dx) < BOX_W) && (32'(dy) < BOX_H);
        read_addr_d = read_addr_q;
        if (in_box) begin
            read_addr_d = ADDR_WIDTH'(((32'(dy) >> SCALE_LOG2) << SPRITE_W_LOG2)
                                      | (32'(dx) >> SCALE_LOG2));
        end
        hit1_d = in_box && video_on && enable;
    end

    // Stage 3: colour key applied to the RAM word aligned with hit2
    always_comb begin
        pixel_valid_d = hit2_q && (q != TRANSPARENT);
        pixel_out_d   = pixel_valid_d ? q : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_addr_q   <= '0;
            hit1_q        <= 1'b0;
            hit2_q        <= 1'b0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            read_addr_q   <= read_addr_d;
            hit1_q        <= hit1_d;
            hit2_q        <= hit1_q;
            pixel_out_q   <= pixel_out_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign read_addr   = read_addr_q;
    assign pixel_out   = pixel_out_q;
    assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_sprite_reader.sv
// Self-checking bench for sprite_reader: unscaled and 2x-scaled instances
// sharing one sprite RAM model, checked against an arithmetic reference.
module tb_sprite_reader;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          frame_start;
    logic [9:0]    origin_x, origin_y, pixel_column, pixel_row;
    logic          video_on;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] q0, q1, po0, po1;
    logic          pv0, pv1;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int passed = 0;

    // Reference model state
    int            ox_m, oy_m;
    logic [AW-1:0] ea [2];
    logic          ev [2][3];
    logic [DW-1:0] ep [2][3];

    always #5 clk = ~clk;

    // Sprite RAM: registered read, one clock latency
    always @(posedge clk) begin
        q0 <= mem[ra0];
        q1 <= mem[ra1];
    end

    sprite_reader #(.SCALE_LOG2(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .frame_start(frame_start),
        .origin_x(origin_x), .origin_y(origin_y),
        .pixel_column(pixel_column), .pixel_row(pixel_row), .video_on(video_on),
        .read_addr(ra0), .q(q0), .pixel_out(po0), .pixel_valid(pv0)
    );

    sprite_reader #(.SCALE_LOG2(1)) u_dut_s1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .frame_start(frame_start),
        .origin_x(origin_x), .origin_y(origin_y),
        .pixel_column(pixel_column), .pixel_row(pixel_row), .video_on(video_on),
        .read_addr(ra1), .q(q1), .pixel_out(po1), .pixel_valid(pv1)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        ox_m = 0;
        oy_m = 0;
        for (int s = 0; s < 2; s++) begin
            ea[s] = '0;
            for (int i = 0; i < 3; i++) begin
                ev[s][i] = 1'b0;
                ep[s][i] = '0;
            end
        end
    endtask

    // Sprite-relative position with plain signed arithmetic
    task automatic map(input int sc, input int col, input int row, output bit ib, output int addr);
        int dx, dy;
        dx   = col - ox_m;
        dy   = row - oy_m;
        ib   = (dx >= 0) && (dy >= 0) && (dx < (128 << sc)) && (dy < (128 << sc));
        addr = ib ? ((dy >> sc) * 128 + (dx >> sc)) : 0;
    endtask

    // Present one pixel, advance the model, then move to the sampling edge
    task automatic step(input int col, input int row, input bit vo, input bit en, input bit fs);
        bit ib;
        int a;
        pixel_column = 10'(col);
        pixel_row    = 10'(row);
        video_on     = vo;
        enable       = en;
        frame_start  = fs;
        for (int s = 0; s < 2; s++) begin
            map(s, col, row, ib, a);
            if (ib) ea[s] = AW'(a);
            for (int i = 2; i > 0; i--) begin
                ev[s][i] = ev[s][i-1];
                ep[s][i] = ep[s][i-1];
            end
            ev[s][0] = ib && vo && en && (mem[a] != 12'hFFF);
            ep[s][0] = ev[s][0] ? mem[a] : 12'h000;
        end
        if (fs) begin
            ox_m = int'(origin_x);
            oy_m = int'(origin_y);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_origin(input int x, input int y);
        origin_x = 10'(x);
        origin_y = 10'(y);
        step(600, 600, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        checks++; if (ra0 !== 15'd0) $display("FAIL rst_init_addr: got %0d want 0", ra0); else passed++;
        checks++; if (po0 !== 12'h000) $display("FAIL rst_init_pix: got %h want 000", po0); else passed++;
        checks++; if (pv0 !== 1'b0) $display("FAIL rst_init_valid: got %b want 0", pv0); else passed++;
        checks++; if (ra1 !== 15'd0) $display("FAIL rst_init_addr_s1: got %0d want 0", ra1); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step(5, 0, 1'b1, 1'b1, 1'b0);
        step(5, 0, 1'b1, 1'b1, 1'b0);
        step(5, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (pv0 !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", pv0); else passed++;
        checks++; if (ra0 !== 15'd5) $display("FAIL rst_pre_addr: got %0d want 5", ra0); else passed++;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (pv0 !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", pv0); else passed++;
        checks++; if (po0 !== 12'h000) $display("FAIL rst_mid_pix: got %h want 000", po0); else passed++;
        checks++; if (ra0 !== 15'd0) $display("FAIL rst_mid_addr: got %0d want 0", ra0); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step(0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (ra0 !== 15'd0) $display("FAIL rst_post_addr: got %0d want 0", ra0); else passed++;
        checks++; if (pv0 !== 1'b0) $display("FAIL rst_post_valid1: got %b want 0", pv0); else passed++;
        step(0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (pv0 !== 1'b0) $display("FAIL rst_post_valid2: got %b want 0", pv0); else passed++;
        step(0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (pv0 !== 1'b1) $display("FAIL rst_post_valid3: got %b want 1", pv0); else passed++;
        checks++; if (po0 !== 12'h0F0) $display("FAIL rst_post_pix3: got %h want 0f0", po0); else passed++;
    endtask

    task automatic test_basic_read();
        set_origin(100, 50);
        step(100, 50, 1'b1, 1'b1, 1'b0);
        checks++; if (ra0 !== 15'd0) $display("FAIL basic_addr: got %0d want 0", ra0); else passed++;
        step(0, 0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b1, 1'b0);
        checks++; if (pv0 !== 1'b1) $display("FAIL basic_valid: got %b want 1", pv0); else passed++;
        checks++; if (po0 !== 12'h0F0) $display("FAIL basic_pix: got %h want 0f0", po0); else passed++;
    endtask

    task automatic test_box_edges();
        step(227, 177, 1'b1, 1'b1, 1'b0);
        checks++; if (ra0 !== 15'd16383) $display("FAIL edge_corner_addr: got %0d want 16383", ra0); else passed++;
        step(228, 50, 1'b1, 1'b1, 1'b0);
        checks++; if (ra0 !== 15'd16383) $display("FAIL edge_right_addr: got %0d want 16383", ra0); else passed++;
        step(99, 50, 1'b1, 1'b1, 1'b0);
        checks++; if (ra0 !== 15'd16383) $display("FAIL edge_left_addr: got %0d want 16383", ra0); else passed++;
        checks++; if (pv0 !== 1'b1 || po0 !== 12'h3C3) $display("FAIL edge_corner_pix: got %b/%h want 1/3c3", pv0, po0); else passed++;
        step(0, 0, 1'b0, 1'b1, 1'b0);
        checks++; if (pv0 !== 1'b0) $display("FAIL edge_right_valid: got %b want 0", pv0); else passed++;
        step(0, 0, 1'b0, 1'b1, 1'b0);
        checks++; if (pv0 !== 1'b0) $display("FAIL edge_left_valid: got %b want 0", pv0); else passed++;
    endtask

    task automatic test_scaling();
        set_origin(0, 0);
        step(3, 5, 1'b1, 1'b1, 1'b0);
        checks++; if (ra1 !== 15'd257) $display("FAIL scale_addr: got %0d want 257", ra1); else passed++;
        step(255, 255, 1'b1, 1'b1, 1'b0);
        checks++; if (ra1 !== 15'd16383) $display("FAIL scale_corner: got %0d want 16383", ra1); else passed++;
        step(256, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (ra1 !== 15'd16383) $display("FAIL scale_out_addr: got %0d want 16383", ra1); else passed++;
        step(600, 600, 1'b0, 1'b1, 1'b0);
        step(600, 600, 1'b0, 1'b1, 1'b0);
        checks++; if (pv1 !== 1'b0) $display("FAIL scale_out_valid: got %b want 0", pv1); else passed++;
    endtask

    task automatic test_transparency();
        step(10, 10, 1'b1, 1'b1, 1'b0);
        step(11, 10, 1'b0, 1'b1, 1'b0);
        step(11, 10, 1'b1, 1'b0, 1'b0);
        checks++; if (pv0 !== 1'b0 || po0 !== 12'h000) $display("FAIL key_transparent: got %b/%h want 0/000", pv0, po0); else passed++;
        step(11, 10, 1'b1, 1'b1, 1'b0);
        checks++; if (pv0 !== 1'b0) $display("FAIL key_video_off: got %b want 0", pv0); else passed++;
        step(600, 600, 1'b0, 1'b1, 1'b0);
        checks++; if (pv0 !== 1'b0) $display("FAIL key_disabled: got %b want 0", pv0); else passed++;
        step(600, 600, 1'b0, 1'b1, 1'b0);
        checks++; if (pv0 !== 1'b1 || po0 !== 12'h123) $display("FAIL key_opaque: got %b/%h want 1/123", pv0, po0); else passed++;
    endtask

    task automatic test_shadow_origin();
        set_origin(100, 50);
        origin_x = 10'd300;
        step(101, 50, 1'b1, 1'b1, 1'b0);
        checks++; if (ra0 !== 15'd1) $display("FAIL shadow_nochange: got %0d want 1", ra0); else passed++;
        step(300, 50, 1'b1, 1'b1, 1'b1);
        checks++; if (ra0 !== 15'd1) $display("FAIL shadow_coincident: got %0d want 1", ra0); else passed++;
        step(300, 50, 1'b1, 1'b1, 1'b0);
        checks++; if (ra0 !== 15'd0) $display("FAIL shadow_new: got %0d want 0", ra0); else passed++;
        origin_x = 10'd1000;
        origin_y = 10'd1000;
        step(0, 0, 1'b0, 1'b1, 1'b1);
        step(1023, 1023, 1'b1, 1'b1, 1'b0);
        checks++; if (ra0 !== 15'd2967) $display("FAIL shadow_far_addr: got %0d want 2967", ra0); else passed++;
        step(0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if (ra0 !== 15'd2967) $display("FAIL shadow_nowrap_addr: got %0d want 2967", ra0); else passed++;
        step(600, 600, 1'b0, 1'b1, 1'b0);
        step(600, 600, 1'b0, 1'b1, 1'b0);
        checks++; if (pv0 !== 1'b0) $display("FAIL shadow_nowrap_valid: got %b want 0", pv0); else passed++;
    endtask

    // Continuous stream across a full row plus random positions, origins and qualifiers
    task automatic test_back_to_back_random(input int n);
        int col, row;
        bit fs;
        for (int k = 0; k < n; k++) begin
            if (k < 160) begin
                col = (ox_m + k - 10) & 1023;
                row = (oy_m + 7) & 1023;
                step(col, row, 1'b1, 1'b1, 1'b0);
            end else begin
                if ($urandom_range(0, 9) == 0) begin
                    origin_x = 10'($urandom_range(0, 1023));
                    origin_y = 10'($urandom_range(0, 1023));
                end
                fs  = ($urandom_range(0, 39) == 0);
                col = (ox_m + int'($urandom_range(0, 300)) - 20) & 1023;
                row = (oy_m + int'($urandom_range(0, 300)) - 20) & 1023;
                step(col, row, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, fs);
            end
            checks++; if (ra0 !== ea[0]) $display("FAIL rnd_addr k=%0d: got %0d want %0d", k, ra0, ea[0]); else passed++;
            checks++; if (pv0 !== ev[0][2]) $display("FAIL rnd_valid k=%0d: got %b want %b", k, pv0, ev[0][2]); else passed++;
            checks++; if (po0 !== ep[0][2]) $display("FAIL rnd_pix k=%0d: got %h want %h", k, po0, ep[0][2]); else passed++;
            checks++; if (ra1 !== ea[1]) $display("FAIL rnd_addr_s1 k=%0d: got %0d want %0d", k, ra1, ea[1]); else passed++;
            checks++; if (pv1 !== ev[1][2]) $display("FAIL rnd_valid_s1 k=%0d: got %b want %b", k, pv1, ev[1][2]); else passed++;
            checks++; if (po1 !== ep[1][2]) $display("FAIL rnd_pix_s1 k=%0d: got %h want %h", k, po1, ep[1][2]); else passed++;
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        frame_start  = 1'b0;
        origin_x     = '0;
        origin_y     = '0;
        pixel_column = '0;
        pixel_row    = '0;
        video_on     = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
        end
        mem[0]     = 12'h0F0;
        mem[5]     = 12'h0A5;
        mem[1290]  = 12'hFFF;
        mem[1291]  = 12'h123;
        mem[16383] = 12'h3C3;
        model_reset();
        #2;
        test_reset();
        test_basic_read();
        test_box_edges();
        test_scaling();
        test_transparency();
        test_shadow_origin();
        test_back_to_back_random(1500);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
